// File: rtl/reg_port_sequencer_if.sv
// Purpose : command, response and register-file port bundle for reg_port_sequencer.
// Latency : n/a (wires only).
// Backpressure: cmd_valid/cmd_ready and rsp_valid/rsp_ready handshakes; rf_* port has none.
// Ports (slave = sequencer view):
//   cmd_valid/cmd_ready/cmd_op/cmd_addr_a/cmd_addr_b/cmd_data : command channel
//   rsp_valid/rsp_ready/rsp_data                              : response channel
//   rf_en/rf_addr/rf_wdata/rf_rdata                           : register file port
interface reg_port_sequencer_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) ();
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_addr_a;
  logic [ADDR_W-1:0] cmd_addr_b;
  logic [DATA_W-1:0] cmd_data;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;

  logic              rf_en;
  logic [ADDR_W-1:0] rf_addr;
  logic [DATA_W-1:0] rf_wdata;
  logic [DATA_W-1:0] rf_rdata;

  // Sequencer side.
  modport slave (
    input  cmd_valid, cmd_op, cmd_addr_a, cmd_addr_b, cmd_data,
    input  rsp_ready, rf_rdata,
    output cmd_ready, rsp_valid, rsp_data,
    output rf_en, rf_addr, rf_wdata
  );

  // Controller / register-file side.
  modport master (
    output cmd_valid, cmd_op, cmd_addr_a, cmd_addr_b, cmd_data,
    output rsp_ready, rf_rdata,
    input  cmd_ready, rsp_valid, rsp_data,
    input  rf_en, rf_addr, rf_wdata
  );
endinterface

// File: rtl/reg_port_sequencer.sv
// Purpose : expands READ/WRITE/COPY/SWAP commands into single-port register-file accesses.
// Latency : response valid 1/1/2/4 port cycles after accept (READ/WRITE/COPY/SWAP).
// Backpressure: one command in flight; cmd_ready only in IDLE, RESP holds until rsp_ready.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : reg_port_sequencer_if.slave (command, response, register-file port)
module reg_port_sequencer #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  reg_port_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_WRITE = 2'b01,
    OP_COPY  = 2'b10,
    OP_SWAP  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    IDLE,
    RD_A,
    RD_B,
    WR_A,
    WR_B,
    RESP
  } state_e;

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [ADDR_W-1:0] addr_a_q, addr_a_d;
  logic [ADDR_W-1:0] addr_b_q, addr_b_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] tmp_a_q, tmp_a_d;
  logic [DATA_W-1:0] tmp_b_q, tmp_b_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      op_q       <= OP_READ;
      addr_a_q   <= '0;
      addr_b_q   <= '0;
      data_q     <= '0;
      tmp_a_q    <= '0;
      tmp_b_q    <= '0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      addr_a_q   <= addr_a_d;
      addr_b_q   <= addr_b_d;
      data_q     <= data_d;
      tmp_a_q    <= tmp_a_d;
      tmp_b_q    <= tmp_b_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_a_d   = addr_a_q;
    addr_b_d   = addr_b_q;
    data_d     = data_q;
    tmp_a_d    = tmp_a_q;
    tmp_b_d    = tmp_b_q;
    rsp_data_d = rsp_data_q;

    bus.cmd_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.rf_en     = 1'b0;
    // Idle/response cycles park the address on a so the port never floats.
    bus.rf_addr   = addr_a_q;
    bus.rf_wdata  = '0;

    case (state_q)
      IDLE: begin
        bus.cmd_ready = 1'b1;
        if (bus.cmd_valid) begin
          op_d     = op_e'(bus.cmd_op);
          addr_a_d = bus.cmd_addr_a;
          addr_b_d = bus.cmd_addr_b;
          data_d   = bus.cmd_data;
          state_d  = (op_e'(bus.cmd_op) == OP_WRITE) ? WR_A : RD_A;
        end
      end

      RD_A: begin
        tmp_a_d = bus.rf_rdata;
        case (op_q)
          OP_READ: begin
            // tmp_a is being loaded on this same edge, so take the value off the port.
            rsp_data_d = bus.rf_rdata;
            state_d    = RESP;
          end
          OP_COPY: state_d = WR_B;
          default: state_d = RD_B;
        endcase
      end

      RD_B: begin
        bus.rf_addr = addr_b_q;
        tmp_b_d     = bus.rf_rdata;
        state_d     = WR_A;
      end

      WR_A: begin
        bus.rf_en    = 1'b1;
        bus.rf_wdata = (op_q == OP_SWAP) ? tmp_b_q : data_q;
        if (op_q == OP_SWAP) begin
          state_d = WR_B;
        end else begin
          rsp_data_d = data_q;
          state_d    = RESP;
        end
      end

      WR_B: begin
        // COPY and SWAP both answer with the value originally read from a.
        bus.rf_en    = 1'b1;
        bus.rf_addr  = addr_b_q;
        bus.rf_wdata = tmp_a_q;
        rsp_data_d   = tmp_a_q;
        state_d      = RESP;
      end

      RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.rsp_data = rsp_data_q;

endmodule
